// File: rtl/cp0_pkg.sv
// Shared constants and types for the CP0 register file.
package cp0_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  // Register numbers
  localparam logic [REG_AW-1:0] CP0_BADVADDR = 5'd8;
  localparam logic [REG_AW-1:0] CP0_COUNT    = 5'd9;
  localparam logic [REG_AW-1:0] CP0_COMPARE  = 5'd11;
  localparam logic [REG_AW-1:0] CP0_STATUS   = 5'd12;
  localparam logic [REG_AW-1:0] CP0_CAUSE    = 5'd13;
  localparam logic [REG_AW-1:0] CP0_EPC      = 5'd14;

  // Status bit positions
  localparam int unsigned STATUS_IE  = 0;
  localparam int unsigned STATUS_EXL = 1;
  localparam int unsigned STATUS_BEV = 22;

  // Cause bit positions
  localparam int unsigned CAUSE_BD        = 31;
  localparam int unsigned CAUSE_TI        = 30;
  localparam int unsigned CAUSE_IP_HW_HI  = 15;
  localparam int unsigned CAUSE_IP_HW_LO  = 10;
  localparam int unsigned CAUSE_EXC_HI    = 6;
  localparam int unsigned CAUSE_EXC_LO    = 2;

  // Masks: what mtc0 may change, and what a read exposes
  localparam logic [XLEN-1:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [XLEN-1:0] STATUS_RMASK = STATUS_WMASK | (32'd1 << STATUS_BEV);
  localparam logic [XLEN-1:0] CAUSE_WMASK  = 32'h0000_0300;
  localparam logic [XLEN-1:0] CAUSE_RMASK  = 32'h8000_FF7C;

  typedef enum logic [4:0] {
    INT  = 5'd0,
    ADEL = 5'd4,
    ADES = 5'd5,
    SYS  = 5'd8,
    BP   = 5'd9,
    RI   = 5'd10,
    CPU  = 5'd11,
    OV   = 5'd12
  } exc_code_t;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer with clock divider and sticky timer interrupt.
module cp0_timer
  import cp0_pkg::*;
#(
  parameter int unsigned COUNT_DIV = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wen,
  input  logic [REG_AW-1:0] waddr,
  input  logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   count,
  output logic [XLEN-1:0]   compare,
  output logic              ti
);

  localparam int unsigned DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [XLEN-1:0]  count_q, count_d;
  logic [XLEN-1:0]  compare_q, compare_d;
  logic             ti_q, ti_d;
  logic             tick;
  logic             count_wr;
  logic             compare_wr;
  logic [XLEN-1:0]  count_inc;

  // Next-state: divider, Count load/increment, Compare load, TI set/clear
  always_comb begin
    tick       = (div_q == DIV_LAST);
    count_wr   = wen && (waddr == CP0_COUNT);
    compare_wr = wen && (waddr == CP0_COMPARE);
    count_inc  = count_q + 32'd1;
    div_d      = tick ? '0 : div_q + DIV_W'(1);
    count_d    = count_q;
    compare_d  = compare_q;
    ti_d       = ti_q;
    if (count_wr) begin
      count_d = wdata;
    end else if (tick) begin
      count_d = count_inc;
      if (count_inc == compare_q) ti_d = 1'b1;
    end
    if (compare_wr) begin
      compare_d = wdata;
      ti_d      = 1'b0;
    end
  end

  // Timer state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q     <= '0;
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      div_q     <= div_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count   = count_q;
  assign compare = compare_q;
  assign ti      = ti_q;

endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file: Status, Cause, EPC, BadVAddr plus the timer.
module cp0_regfile
  import cp0_pkg::*;
#(
  parameter int unsigned      COUNT_DIV    = 2,
  parameter logic [XLEN-1:0]  STATUS_RESET = 32'h0040_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] raddr,
  output logic [XLEN-1:0]   rdata,
  input  logic              wen,
  input  logic [REG_AW-1:0] waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic              exp_en,
  input  logic              exl_clean,
  input  logic [XLEN-1:0]   exp_epc,
  input  logic [4:0]        exp_code,
  input  logic              exp_bd,
  input  logic [XLEN-1:0]   exp_bad_vaddr,
  input  logic              exp_bad_vaddr_wen,
  input  logic [5:0]        hw_int,
  output logic [XLEN-1:0]   epc_address,
  output logic              allow_interrupt,
  output logic [7:0]        interrupt_flag,
  output logic              timer_int
);

  logic [XLEN-1:0] status_q, status_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] badvaddr_q, badvaddr_d;
  logic [XLEN-1:0] count, compare;
  logic            ti;
  logic            mtc0_en;
  logic            exl;

  // An exception drops any mtc0; an eret drops only an mtc0 to Status
  assign mtc0_en = wen && !exp_en && !(exl_clean && (waddr == CP0_STATUS));
  assign exl     = status_q[STATUS_EXL];

  cp0_timer #(
    .COUNT_DIV (COUNT_DIV)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .wen     (mtc0_en),
    .waddr   (waddr),
    .wdata   (wdata),
    .count   (count),
    .compare (compare),
    .ti      (ti)
  );

  // Next-state for Status, Cause, EPC and BadVAddr
  always_comb begin
    status_d   = status_q;
    cause_d    = cause_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;

    if (mtc0_en && (waddr == CP0_STATUS))
      status_d = (status_q & ~STATUS_WMASK) | (wdata & STATUS_WMASK);
    if (mtc0_en && (waddr == CP0_CAUSE))
      cause_d = (cause_q & ~CAUSE_WMASK) | (wdata & CAUSE_WMASK);
    if (mtc0_en && (waddr == CP0_EPC))
      epc_d = wdata;

    // Hardware interrupt pending bits sample the lines every cycle
    cause_d[CAUSE_IP_HW_HI:CAUSE_IP_HW_LO] = {hw_int[5] | ti, hw_int[4:0]};

    if (exp_en) begin
      status_d[STATUS_EXL]                 = 1'b1;
      cause_d[CAUSE_EXC_HI:CAUSE_EXC_LO]   = exp_code;
      if (!exl) begin
        epc_d             = exp_epc;
        cause_d[CAUSE_BD] = exp_bd;
      end
      if (exp_bad_vaddr_wen) badvaddr_d = exp_bad_vaddr;
    end else if (exl_clean) begin
      status_d[STATUS_EXL] = 1'b0;
    end

    // TI lives in the timer
    cause_d[CAUSE_TI] = 1'b0;
  end

  // Architectural registers
  always_ff @(posedge clk) begin
    if (rst) begin
      status_q   <= STATUS_RESET;
      cause_q    <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
    end else begin
      status_q   <= status_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
    end
  end

  // mfc0 read mux, registers only (no bypass of same-cycle writes)
  always_comb begin
    rdata = '0;
    case (raddr)
      CP0_BADVADDR: rdata = badvaddr_q;
      CP0_COUNT:    rdata = count;
      CP0_COMPARE:  rdata = compare;
      CP0_STATUS:   rdata = status_q & STATUS_RMASK;
      CP0_CAUSE:    rdata = (cause_q & CAUSE_RMASK) | (XLEN'(ti) << CAUSE_TI);
      CP0_EPC:      rdata = epc_q;
      default:      rdata = '0;
    endcase
  end

  assign epc_address     = epc_q;
  assign allow_interrupt = status_q[STATUS_IE] & ~status_q[STATUS_EXL];
  assign interrupt_flag  = cause_q[15:8] & status_q[15:8];
  assign timer_int       = ti;

endmodule

// File: tb/tb_cp0_regfile.sv
// Self-checking bench for cp0_regfile: vector table plus timer/reset sequences.
module tb_cp0_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  raddr;
  logic [31:0] rdata;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        exp_en;
  logic        exl_clean;
  logic [31:0] exp_epc;
  logic [4:0]  exp_code;
  logic        exp_bd;
  logic [31:0] exp_bad_vaddr;
  logic        exp_bad_vaddr_wen;
  logic [5:0]  hw_int;
  logic [31:0] epc_address;
  logic        allow_interrupt;
  logic [7:0]  interrupt_flag;
  logic        timer_int;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cp0_regfile dut (
    .clk               (clk),
    .rst               (rst),
    .raddr             (raddr),
    .rdata             (rdata),
    .wen               (wen),
    .waddr             (waddr),
    .wdata             (wdata),
    .exp_en            (exp_en),
    .exl_clean         (exl_clean),
    .exp_epc           (exp_epc),
    .exp_code          (exp_code),
    .exp_bd            (exp_bd),
    .exp_bad_vaddr     (exp_bad_vaddr),
    .exp_bad_vaddr_wen (exp_bad_vaddr_wen),
    .hw_int            (hw_int),
    .epc_address       (epc_address),
    .allow_interrupt   (allow_interrupt),
    .interrupt_flag    (interrupt_flag),
    .timer_int         (timer_int)
  );

  typedef struct {
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        exp_en;
    logic        exl_clean;
    logic [31:0] epc;
    logic [4:0]  code;
    logic        bd;
    logic [31:0] bva;
    logic        bva_wen;
    logic [5:0]  hw;
    logic [4:0]  raddr;
    logic [31:0] e_rdata;
    logic        e_allow;
    logic [7:0]  e_iflag;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic        allow;
    logic [7:0]  iflag;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                     input logic ee, input logic ec, input logic [31:0] ep,
                     input logic [4:0] cd, input logic bd, input logic [31:0] bv,
                     input logic bvw, input logic [5:0] hw, input logic [4:0] ra,
                     input logic [31:0] er, input logic ea, input logic [7:0] ei);
    vec_t v;
    v.wen = w; v.waddr = wa; v.wdata = wd; v.exp_en = ee; v.exl_clean = ec;
    v.epc = ep; v.code = cd; v.bd = bd; v.bva = bv; v.bva_wen = bvw; v.hw = hw;
    v.raddr = ra; v.e_rdata = er; v.e_allow = ea; v.e_iflag = ei;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    wen = 1'b0; waddr = '0; wdata = '0; exp_en = 1'b0; exl_clean = 1'b0;
    exp_epc = '0; exp_code = '0; exp_bd = 1'b0; exp_bad_vaddr = '0;
    exp_bad_vaddr_wen = 1'b0; hw_int = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    wen = 1'b1; waddr = a; wdata = d;
    tick();
    wen = 1'b0;
  endtask

  initial begin
    vec_t v;
    exp_t e;
    int   cycles;
    bit   seen;

    rst = 1'b1;
    raddr = '0;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;

    //  w  wa  wdata          ee ec epc            cd  bd bva            bvw hw     ra  expected rdata  al iflag
    add(0, 0,  32'h0,         0, 0, 32'h0,         0,  0, 32'h0,         0,  6'h00, 8,  32'h0,          0, 8'h00);
    add(0, 0,  32'h0,         0, 0, 32'h0,         0,  0, 32'h0,         0,  6'h00, 11, 32'h0,          0, 8'h00);
    add(0, 0,  32'h0,         0, 0, 32'h0,         0,  0, 32'h0,         0,  6'h00, 12, 32'h0040_0000,  0, 8'h00);
    add(0, 0,  32'h0,         0, 0, 32'h0,         0,  0, 32'h0,         0,  6'h00, 13, 32'h0,          0, 8'h00);
    add(0, 0,  32'h0,         0, 0, 32'h0,         0,  0, 32'h0,         0,  6'h00, 14, 32'h0,          0, 8'h00);
    add(0, 0,  32'h0,         0, 0, 32'h0,         0,  0, 32'h0,         0,  6'h00, 0,  32'h0,          0, 8'h00);
    add(1, 12, 32'hFFFF_FFFF, 0, 0, 32'h0,         0,  0, 32'h0,         0,  6'h00, 12, 32'h0040_FF03,  0, 8'h00);
    add(1, 12, 32'h0000_FF01, 0, 0, 32'h0,         0,  0, 32'h0,         0,  6'h00, 12, 32'h0040_FF01,  1, 8'h00);
    add(1, 8,  32'hDEAD_BEEF, 0, 0, 32'h0,         0,  0, 32'h0,         0,  6'h00, 8,  32'h0,          1, 8'h00);
    add(1, 7,  32'h0000_0055, 0, 0, 32'h0,         0,  0, 32'h0,         0,  6'h00, 7,  32'h0,          1, 8'h00);
    add(1, 14, 32'h0,         1, 0, 32'hBFC0_0100, 4,  1, 32'h1234_5671, 1,  6'h00, 14, 32'hBFC0_0100,  0, 8'h00);
    add(0, 0,  32'h0,         0, 0, 32'h0,         0,  0, 32'h0,         0,  6'h00, 8,  32'h1234_5671,  0, 8'h00);
    add(0, 0,  32'h0,         0, 0, 32'h0,         0,  0, 32'h0,         0,  6'h00, 13, 32'h8000_0010,  0, 8'h00);
    add(0, 0,  32'h0,         0, 0, 32'h0,         0,  0, 32'h0,         0,  6'h00, 12, 32'h0040_FF03,  0, 8'h00);
    add(0, 0,  32'h0,         1, 0, 32'h0000_0004, 12, 0, 32'h0000_FFFF, 0,  6'h00, 14, 32'hBFC0_0100,  0, 8'h00);
    add(0, 0,  32'h0,         0, 0, 32'h0,         0,  0, 32'h0,         0,  6'h00, 13, 32'h8000_0030,  0, 8'h00);
    add(0, 0,  32'h0,         0, 0, 32'h0,         0,  0, 32'h0,         0,  6'h00, 8,  32'h1234_5671,  0, 8'h00);
    add(1, 12, 32'h0,         0, 1, 32'h0,         0,  0, 32'h0,         0,  6'h00, 12, 32'h0040_FF01,  1, 8'h00);
    add(0, 0,  32'h0,         0, 0, 32'h0,         0,  0, 32'h0,         0,  6'h00, 14, 32'hBFC0_0100,  1, 8'h00);
    add(1, 14, 32'h0000_0100, 0, 1, 32'h0,         0,  0, 32'h0,         0,  6'h00, 14, 32'h0000_0100,  1, 8'h00);
    add(0, 0,  32'h0,         1, 1, 32'h0000_0200, 8,  0, 32'h0,         0,  6'h00, 12, 32'h0040_FF03,  0, 8'h00);
    add(0, 0,  32'h0,         0, 0, 32'h0,         0,  0, 32'h0,         0,  6'h00, 13, 32'h0000_0020,  0, 8'h00);
    add(0, 0,  32'h0,         0, 1, 32'h0,         0,  0, 32'h0,         0,  6'h00, 14, 32'h0000_0200,  1, 8'h00);
    add(0, 0,  32'h0,         0, 0, 32'h0,         0,  0, 32'h0,         0,  6'h01, 12, 32'h0040_FF01,  1, 8'h04);
    add(1, 13, 32'h0000_0300, 0, 0, 32'h0,         0,  0, 32'h0,         0,  6'h01, 13, 32'h0000_0720,  1, 8'h07);
    add(1, 13, 32'h0,         0, 0, 32'h0,         0,  0, 32'h0,         0,  6'h00, 13, 32'h0000_0020,  1, 8'h00);

    // Table: one cycle of events per row, expectations queued at drive time
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      wen = v.wen; waddr = v.waddr; wdata = v.wdata;
      exp_en = v.exp_en; exl_clean = v.exl_clean; exp_epc = v.epc;
      exp_code = v.code; exp_bd = v.bd; exp_bad_vaddr = v.bva;
      exp_bad_vaddr_wen = v.bva_wen; hw_int = v.hw; raddr = v.raddr;
      sb.push_back('{i, v.e_rdata, v.e_allow, v.e_iflag});
      tick();
      e = sb.pop_front();
      check32($sformatf("vec%0d_rdata", e.idx), rdata, e.rdata);
      check32($sformatf("vec%0d_allow", e.idx), 32'(allow_interrupt), 32'(e.allow));
      check32($sformatf("vec%0d_iflag", e.idx), 32'(interrupt_flag), 32'(e.iflag));
    end
    idle_inputs();
    check32("epc_address", epc_address, 32'h0000_0200);

    // Timer interrupt rise: Compare=5, Count=0
    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'd0);
    cycles = 0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      tick();
      cycles++;
      if (timer_int) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL ti_rise: timer_int stayed 0 for 40 cycles, required 1");
    end else begin
      checks++;
      if (cycles < 9 || cycles > 10) begin
        failures++;
        $display("FAIL ti_latency: rose after %0d cycles, required 9 or 10", cycles);
      end
      raddr = 5'd9;
      #1;
      check32("ti_count", rdata, 32'd5);
      raddr = 5'd13;
      #1;
      check32("ti_cause_bit", 32'(rdata[30]), 32'd1);
      tick();
      check32("ti_iflag7", 32'(interrupt_flag), 32'h80);
    end
    mtc0(5'd11, 32'h0000_1000);
    check32("ti_clear", 32'(timer_int), 32'd0);
    tick();
    check32("ti_iflag_clear", 32'(interrupt_flag), 32'h00);

    // Compare write on the same cycle Count increments to Compare: clear wins
    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'd3);
    raddr = 5'd9;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      tick();
      if (rdata == 32'd4) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL cw_count4: Count never read 4 within 10 cycles, last %h", rdata);
    end else begin
      tick();
      mtc0(5'd11, 32'h0000_0077);
      check32("cw_count5", rdata, 32'd5);
      check32("cw_ti", 32'(timer_int), 32'd0);
      tick();
      check32("cw_ti_hold", 32'(timer_int), 32'd0);
    end

    // Reset mid-count restarts Count and the divider
    rst = 1'b1;
    tick();
    rst = 1'b0;
    raddr = 5'd9;
    #1;
    check32("rst_count", rdata, 32'd0);
    raddr = 5'd12;
    #1;
    check32("rst_status", rdata, 32'h0040_0000);
    check32("rst_epc", epc_address, 32'd0);
    check32("rst_allow", 32'(allow_interrupt), 32'd0);
    check32("rst_timer", 32'(timer_int), 32'd0);
    check32("rst_iflag", 32'(interrupt_flag), 32'd0);
    raddr = 5'd9;
    tick();
    check32("rst_count_c1", rdata, 32'd0);
    tick();
    check32("rst_count_c2", rdata, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
